// File: rtl/exe_hazard_controller.sv
// ---------------------------------------------------------------------------
// exe_hazard_controller
//
// Pipeline hazard and memory-stall controller for a five-stage pipeline.
// It works out, for the instruction in ID, whether the pipeline must stall,
// flush or freeze, and which forwarding path each source operand should use.
//
// A small two-state FSM (IDLE / MEM_WAIT) tracks a data-memory access that
// did not finish in its first cycle. While it waits, every pipeline register
// is frozen. An 8-bit counter bounds the wait at MEM_TIMEOUT cycles. If the
// bound is hit, the access is abandoned and the sticky timeout_err flag is set.
//
// Optional feature macro: HAZARD_FORWARDING_EN
//   undefined : any EXE or MEM writeback that matches an ID source stalls;
//               sel_src1/sel_src2 are tied to 0 (register file).
//   defined   : only a load-use hazard stalls. Other matches are resolved by
//               forwarding (1 = EXE ALU result, 2 = MEM result).
//
// Parameters
//   MEM_TIMEOUT       maximum MEM_WAIT cycles before abort (1..255)
//
// Ports
//   clk               rising-edge clock
//   rst               asynchronous, active-low reset
//   id_src1/id_src2   source register numbers of the ID instruction
//   id_two_src        id_src2 is a real operand
//   id_valid          ID holds a real instruction
//   exe_wb_en         EXE instruction writes the register file
//   exe_wb_reg_dest   EXE destination register
//   exe_mem_r_en      EXE instruction reads data memory (load)
//   exe_mem_w_en      EXE instruction writes data memory (store)
//   exe_branch_taken  branch resolved taken in EXE
//   mem_wb_en         MEM instruction writes the register file
//   mem_wb_reg_dest   MEM destination register
//   mem_ready         data memory completes the access this cycle
//   stall_if          hold the PC
//   stall_id          hold the IF/ID register
//   flush_id          clear the IF/ID register
//   flush_exe         insert a bubble into the ID/EXE register
//   freeze_all        hold every pipeline register
//   sel_src1/sel_src2 forwarding select (0 regfile, 1 EXE, 2 MEM)
//   timeout_err       sticky memory-timeout flag
// ---------------------------------------------------------------------------
module exe_hazard_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] id_src1,
  input  logic [3:0] id_src2,
  input  logic       id_two_src,
  input  logic       id_valid,
  input  logic       exe_wb_en,
  input  logic [3:0] exe_wb_reg_dest,
  input  logic       exe_mem_r_en,
  input  logic       exe_mem_w_en,
  input  logic       exe_branch_taken,
  input  logic       mem_wb_en,
  input  logic [3:0] mem_wb_reg_dest,
  input  logic       mem_ready,
  output logic       stall_if,
  output logic       stall_id,
  output logic       flush_id,
  output logic       flush_exe,
  output logic       freeze_all,
  output logic [1:0] sel_src1,
  output logic [1:0] sel_src2,
  output logic       timeout_err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_next;
  logic       timeout_set;
  logic       mem_freeze;
  logic       mem_acc;

  logic       exe_match1;
  logic       exe_match2;
  logic       mem_match1;
  logic       mem_match2;
  logic       hazard;

  assign mem_acc = exe_mem_r_en | exe_mem_w_en;

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (timeout_set) begin
        timeout_err <= 1'b1;
      end
    end
  end

  // Memory-wait FSM. The freeze is raised in the same cycle that the slow
  // access is first seen. It is dropped in the cycle that the memory answers,
  // or in the cycle the access is abandoned, so the pipeline moves on at once.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    timeout_set   = 1'b0;
    mem_freeze    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_acc && !mem_ready) begin
          mem_freeze    = 1'b1;
          state_next    = MEM_WAIT;
          wait_cnt_next = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_next    = IDLE;
          wait_cnt_next = 8'd0;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          timeout_set   = 1'b1;
          state_next    = IDLE;
          wait_cnt_next = 8'd0;
        end else begin
          mem_freeze    = 1'b1;
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      default: begin
        state_next    = IDLE;
        wait_cnt_next = 8'd0;
      end
    endcase
  end

  // The freeze is gated by reset so that it drops the moment reset is
  // asserted. Otherwise a load still in EXE would re-raise it from IDLE.
  assign freeze_all = rst & mem_freeze;

  // Source/destination matches against the two older stages. src2 only
  // counts when the instruction really reads a second operand.
  always_comb begin
    exe_match1 = id_valid & exe_wb_en & (exe_wb_reg_dest == id_src1);
    exe_match2 = id_valid & id_two_src & exe_wb_en & (exe_wb_reg_dest == id_src2);
    mem_match1 = id_valid & mem_wb_en & (mem_wb_reg_dest == id_src1);
    mem_match2 = id_valid & id_two_src & mem_wb_en & (mem_wb_reg_dest == id_src2);
  end

`ifdef HAZARD_FORWARDING_EN
  // With forwarding, only a load in EXE cannot supply its value in time.
  // When both stages match, EXE holds the younger value and wins.
  always_comb begin
    hazard   = exe_mem_r_en & (exe_match1 | exe_match2);
    sel_src1 = 2'd0;
    sel_src2 = 2'd0;
    if (exe_match1) begin
      sel_src1 = 2'd1;
    end else if (mem_match1) begin
      sel_src1 = 2'd2;
    end
    if (exe_match2) begin
      sel_src2 = 2'd1;
    end else if (mem_match2) begin
      sel_src2 = 2'd2;
    end
  end
`else
  // Without forwarding, every in-flight writeback to a source must retire
  // before the ID instruction may proceed.
  always_comb begin
    hazard   = exe_match1 | exe_match2 | mem_match1 | mem_match2;
    sel_src1 = 2'd0;
    sel_src2 = 2'd0;
  end
`endif

  // Pipeline control priority: freeze, then taken branch, then data hazard.
  // A taken branch discards the ID instruction, so any hazard it had is moot.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    flush_id  = 1'b0;
    flush_exe = 1'b0;
    if (freeze_all) begin
      stall_if  = 1'b0;
    end else if (exe_branch_taken) begin
      flush_id  = 1'b1;
      flush_exe = 1'b1;
    end else if (hazard) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      flush_exe = 1'b1;
    end
  end

endmodule

// File: doc/exe_hazard_controller.md
EXE_HAZARD_CONTROLLER -- requirements
Module: exe_hazard_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, which is the maximum number of MEM_WAIT cycles before the access is aborted (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports id_src1 and id_src2, input, 4 bits each: the source register numbers of the instruction in ID.
REQ-005 SHALL have port id_two_src, input, 1 bit: id_src2 is a real operand.
REQ-006 SHALL have port id_valid, input, 1 bit: ID holds a real instruction.
REQ-007 SHALL have ports exe_wb_en (1 bit), exe_wb_reg_dest (4 bits), exe_mem_r_en (1 bit), exe_mem_w_en (1 bit) and exe_branch_taken (1 bit), all inputs: the EXE stage control signals.
REQ-008 SHALL have ports mem_wb_en (1 bit) and mem_wb_reg_dest (4 bits), both inputs: the MEM stage writeback control.
REQ-009 SHALL have port mem_ready, input, 1 bit: the data memory completes the current access this cycle.
REQ-010 SHALL have ports stall_if and stall_id, outputs, 1 bit each: hold the PC and the IF/ID register.
REQ-011 SHALL have port flush_id, output, 1 bit: clear the IF/ID register.
REQ-012 SHALL have port flush_exe, output, 1 bit: insert a bubble into the ID/EXE register.
REQ-013 SHALL have port freeze_all, output, 1 bit: hold every pipeline register.
REQ-014 SHALL have ports sel_src1 and sel_src2, outputs, 2 bits each: forwarding select, where 0 = register file, 1 = EXE ALU result, 2 = MEM result.
REQ-015 SHALL have port timeout_err, output, 1 bit: sticky memory-timeout flag.

Function
REQ-016 SHALL implement a registered FSM with states IDLE and MEM_WAIT, plus an 8-bit wait counter; all outputs SHALL be combinational from the state and the inputs.
REQ-017 SHALL define mem_acc = exe_mem_r_en | exe_mem_w_en.
REQ-018 In IDLE with mem_acc=1 and mem_ready=0, the block SHALL assert freeze_all in the same cycle, load the counter with 1, and move to MEM_WAIT.
REQ-019 In IDLE with mem_acc=1 and mem_ready=1, the access is zero-wait: the block SHALL NOT assert freeze_all and SHALL stay in IDLE.
REQ-020 In MEM_WAIT with mem_ready=1, the block SHALL deassert freeze_all that cycle, move to IDLE, and clear the counter.
REQ-021 In MEM_WAIT with mem_ready=0 and counter=MEM_TIMEOUT, the block SHALL set timeout_err, deassert freeze_all, and move to IDLE (abort).
REQ-022 In MEM_WAIT otherwise, the block SHALL hold freeze_all=1 and increment the counter.
REQ-023 Whenever freeze_all=1, the block SHALL drive stall_if, stall_id, flush_id and flush_exe to 0 (freeze has the highest priority).
REQ-024 When freeze_all=0 and exe_branch_taken=1, the block SHALL assert flush_id and flush_exe for that cycle and SHALL drive stall_if and stall_id to 0 (branch beats hazard).
REQ-025 Hazard match: srcN matches a stage when that stage's wb_en=1, its dest equals srcN, id_valid=1, and (for src2) id_two_src=1.
REQ-026 On a hazard stall with no freeze and no branch, the block SHALL assert stall_if, stall_id and flush_exe; flush_id SHALL stay 0.
REQ-027 A simultaneous match on both EXE and MEM for the same source SHALL resolve to EXE, the younger value.
REQ-028 timeout_err SHALL remain set until reset.

Reset
REQ-029 While rst=0, the block SHALL force state IDLE, counter 0 and timeout_err 0, asynchronously.
REQ-030 With the block in reset and all inputs 0, every output SHALL be 0.
REQ-031 Reset asserted in MEM_WAIT SHALL release freeze_all immediately, without waiting for a clock edge.

Configuration
REQ-032 With macro HAZARD_FORWARDING_EN defined, the block SHALL stall only on a load-use hazard (exe_mem_r_en=1 and an EXE match).
REQ-033 With HAZARD_FORWARDING_EN defined, other EXE matches SHALL give sel=1 and MEM matches SHALL give sel=2.
REQ-034 Without HAZARD_FORWARDING_EN, any EXE or MEM match SHALL stall, and sel_src1 and sel_src2 SHALL be constant 0.

Verification
REQ-035 The bench SHALL cover: exe_mem_r_en=1 with mem_ready low for 3 cycles then high -> freeze_all high for exactly 3 cycles, low on the ready cycle, state IDLE afterwards.
REQ-036 The bench SHALL cover: MEM_TIMEOUT=4 with mem_ready held 0 -> freeze_all high for 4 cycles, timeout_err=1 from the 5th edge, and timeout_err still 1 after 20 further cycles.
REQ-037 The bench SHALL cover: exe_branch_taken=1 together with an EXE match on id_src1 -> flush_id=1, flush_exe=1, stall_if=0.
REQ-038 The bench SHALL cover, with HAZARD_FORWARDING_EN: exe_wb_en=1, exe_wb_reg_dest=5, id_src1=5, exe_mem_r_en=0 -> sel_src1=1 with no stall; then exe_mem_r_en=1 -> stall_if=1, stall_id=1, flush_exe=1.
REQ-039 The bench SHALL cover, without HAZARD_FORWARDING_EN: mem_wb_en=1, mem_wb_reg_dest=3, id_src2=3, id_two_src=0 -> no stall; then id_two_src=1 -> stall.
REQ-040 The bench SHALL cover: rst driven low mid-MEM_WAIT -> freeze_all=0 before the next clock edge, and timeout_err=0.
